// File: rtl/sched_rr4_if.sv
// Bundle of FIFO-side signals for sched_rr4: source FIFO flags/data in, destination pushes out.
// master = scheduler side, slave = FIFO/environment side.
interface sched_rr4_if #(
  parameter int DATA_W = 12
);
  logic [3:0]        empty;
  logic [3:0]        almost_full;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant;
  logic              idle;

  modport master (
    input  empty, almost_full, data_in0, data_in1, data_in2, data_in3,
    output pop, push, data_out, grant, idle
  );

  modport slave (
    output empty, almost_full, data_in0, data_in1, data_in2, data_in3,
    input  pop, push, data_out, grant, idle
  );
endinterface

// File: rtl/sched_rr4.sv
// Weighted round-robin scheduler draining class FIFOs 0-3 into destination FIFOs 4-7.
// Optional SCHED_STRICT_PRIO_EN: selections pick the lowest-index non-empty source.
module sched_rr4 #(
  parameter int DATA_W = 12,
  parameter int BURST  = 4
) (
  input  logic       clk,
  input  logic       reset,
  sched_rr4_if.master bus
);

  typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        pv_q;
  logic [1:0]  psrc_q;

  logic              af_any;
  logic              pop_en;
  logic [3:0]        avail;
  logic [2:0]        nxt;
  logic [DATA_W-1:0] word;

  // Returns {found, index} of the next source to own.
  function automatic logic [2:0] pick_src(input logic [1:0] from, input logic [3:0] av);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
`ifdef SCHED_STRICT_PRIO_EN
    idx = from;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 2'(i);
      if (av[idx] && !res[2]) res = {1'b1, idx};
    end
`else
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (av[idx] && !res[2]) res = {1'b1, idx};
    end
`endif
    return res;
  endfunction

  assign af_any = |bus.almost_full;
  assign avail  = ~bus.empty;
  assign pop_en = (state_q == SERVE) && !bus.empty[cur_q] && !af_any;
  assign nxt    = pick_src(cur_q, avail);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if ((|avail) && !af_any) begin
          state_d = SERVE;
          cur_d   = nxt[1:0];
          bcnt_d  = '0;
        end
      end
      SERVE: begin
        if (af_any) begin
          state_d = HOLD;
        end else if (pop_en) begin
          if (bcnt_q == 4'(BURST - 1)) begin
            cur_d  = nxt[1:0];
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end else begin
          bcnt_d = '0;
          if (nxt[2]) cur_d = nxt[1:0];
          else        state_d = IDLE;
        end
      end
      HOLD: begin
        if (!af_any) state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= 2'd3;
      bcnt_q  <= '0;
      pv_q    <= 1'b0;
      psrc_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bcnt_q  <= bcnt_d;
      pv_q    <= pop_en;
      psrc_q  <= cur_q;
    end
  end

  always_comb begin
    word = '0;
    case (psrc_q)
      2'd0: word = bus.data_in0;
      2'd1: word = bus.data_in1;
      2'd2: word = bus.data_in2;
      default: word = bus.data_in3;
    endcase
  end

  // Gating with reset drops a word popped the cycle before reset.
  assign bus.data_out = (pv_q && !reset) ? word : '0;
  assign bus.push     = (pv_q && !reset) ? (4'b0001 << word[9:8]) : '0;
  assign bus.pop      = pop_en ? (4'b0001 << cur_q) : '0;
  assign bus.grant    = cur_q;
  assign bus.idle     = (state_q == IDLE) && !pv_q;

endmodule

// File: tb/tb_sched_rr4.sv
// Self-checking bench for sched_rr4: directed vector table, burst-order check, randomized run
// against a cycle-level reference model built from the scheduling rules.
module tb_sched_rr4;
  localparam int BURST = 4;

  typedef enum int {M_IDLE, M_SERVE, M_HOLD} mmode_t;
  typedef logic [11:0] word_q_t [$];

  typedef struct {
    logic        rst;
    logic [3:0]  af;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [11:0] dout;
    logic [1:0]  grant;
    logic        idle;
    int          ld_src;
    int          ld_n;
    logic [11:0] ld_base;
    logic [11:0] ld_step;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sched_rr4_if #(.DATA_W(12)) bus ();

  sched_rr4 #(.DATA_W(12), .BURST(BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  word_q_t     q [4];
  logic [11:0] din [4];
  assign bus.data_in0 = din[0];
  assign bus.data_in1 = din[1];
  assign bus.data_in2 = din[2];
  assign bus.data_in3 = din[3];

  mmode_t      m_mode;
  int          m_cur;
  int          m_bcnt;
  bit          m_pv;
  logic [11:0] m_word;
  bit          m_valid;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(int from, logic [3:0] emp);
`ifdef SCHED_STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) if (!emp[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (!emp[(from + k) % 4]) return (from + k) % 4;
`endif
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [3:0] af,
                      output logic [3:0] s_pop, output logic [3:0] s_push,
                      output logic [11:0] s_dout, output logic [1:0] s_grant,
                      output logic s_idle);
    logic [3:0]  emp;
    logic [3:0]  e_pop;
    logic        popped;
    logic [11:0] w;
    int          p;
    reset = rst;
    bus.almost_full = af;
    for (int i = 0; i < 4; i++) emp[i] = (q[i].size() == 0);
    bus.empty = emp;
    @(negedge clk);
    s_pop = bus.pop; s_push = bus.push; s_dout = bus.data_out;
    s_grant = bus.grant; s_idle = bus.idle;
    popped = m_valid && (m_mode == M_SERVE) && !emp[m_cur] && (af == 4'd0);
    if (m_valid) begin
      e_pop = popped ? (4'b0001 << m_cur) : 4'd0;
      chk("model_pop",   12'(s_pop),   12'(e_pop));
      chk("model_push",  12'(s_push),  (m_pv && !rst) ? 12'(4'b0001 << m_word[9:8]) : 12'd0);
      chk("model_dout",  s_dout,       (m_pv && !rst) ? m_word : 12'd0);
      chk("model_grant", 12'(s_grant), 12'(m_cur));
      chk("model_idle",  12'(s_idle),  12'((m_mode == M_IDLE) && !m_pv));
    end
    @(posedge clk);
    #1;
    w = '0;
    if (popped) begin
      w = q[m_cur].pop_front();
      din[m_cur] = w;
    end
    p = pick(m_cur, emp);
    if (rst) begin
      m_mode = M_IDLE; m_cur = 3; m_bcnt = 0; m_pv = 0; m_valid = 1;
    end else begin
      m_pv = popped;
      if (popped) m_word = w;
      case (m_mode)
        M_IDLE:
          if (emp != 4'hF && af == 4'd0) begin
            m_mode = M_SERVE; m_cur = p; m_bcnt = 0;
          end
        M_SERVE:
          if (af != 4'd0) m_mode = M_HOLD;
          else if (popped) begin
            if (m_bcnt == BURST - 1) begin m_cur = p; m_bcnt = 0; end
            else m_bcnt++;
          end else begin
            m_bcnt = 0;
            if (p < 0) m_mode = M_IDLE;
            else m_cur = p;
          end
        default:
          if (af == 4'd0) m_mode = M_SERVE;
      endcase
    end
  endtask

  task automatic load(input int src, input int n, input logic [11:0] base, input logic [11:0] stp);
    for (int j = 0; j < n; j++) q[src].push_back(base + 12'(j) * stp);
  endtask

  vec_t        tv [$];
  logic [3:0]  s_pop, s_push;
  logic [11:0] s_dout;
  logic [1:0]  s_grant;
  logic        s_idle;
  int          order [$];
  int          exp_order [$];

  initial begin
    checks = 0; errors = 0; m_valid = 0; m_pv = 0; m_mode = M_IDLE; m_cur = 3; m_bcnt = 0;
    m_word = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    reset = 1'b1; bus.almost_full = '0; bus.empty = 4'hF;

    // rst af pop push dout grant idle | load src n base step
    tv.push_back('{1, 4'h0, 4'h0, 4'h0, 12'h000, 2'd3, 1, 0, 3, 12'h100, 12'h100});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd3, 1, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h1, 4'h0, 12'h000, 2'd0, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h1, 4'h2, 12'h100, 2'd0, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h1, 4'h4, 12'h200, 2'd0, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h8, 12'h300, 2'd0, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd0, 1, 0, 0, 12'h000, 12'h000});
    // back-pressure mid-burst on source 1
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd0, 1, 1, 5, 12'h201, 12'h001});
    tv.push_back('{0, 4'h0, 4'h2, 4'h0, 12'h000, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h2, 4'h4, 12'h201, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h4, 4'h0, 4'h4, 12'h202, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h4, 4'h0, 4'h0, 12'h000, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h2, 4'h0, 12'h000, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h2, 4'h4, 12'h203, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h2, 4'h4, 12'h204, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h4, 12'h205, 2'd1, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd1, 1, 0, 0, 12'h000, 12'h000});
    // reset the cycle after a pop: in-flight word dropped
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd1, 1, 2, 2, 12'h321, 12'h001});
    tv.push_back('{0, 4'h0, 4'h4, 4'h0, 12'h000, 2'd2, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{1, 4'h0, 4'h4, 4'h0, 12'h000, 2'd2, 0, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd3, 1, 0, 0, 12'h000, 12'h000});
    tv.push_back('{0, 4'h0, 4'h0, 4'h0, 12'h000, 2'd3, 1, 0, 0, 12'h000, 12'h000});

    step(1'b1, 4'h0, s_pop, s_push, s_dout, s_grant, s_idle);

    foreach (tv[i]) begin
      if (tv[i].ld_n > 0) load(tv[i].ld_src, tv[i].ld_n, tv[i].ld_base, tv[i].ld_step);
      step(tv[i].rst, tv[i].af, s_pop, s_push, s_dout, s_grant, s_idle);
      chk($sformatf("vec%0d_pop", i),   12'(s_pop),   12'(tv[i].pop));
      chk($sformatf("vec%0d_push", i),  12'(s_push),  12'(tv[i].push));
      chk($sformatf("vec%0d_dout", i),  s_dout,       tv[i].dout);
      chk($sformatf("vec%0d_grant", i), 12'(s_grant), 12'(tv[i].grant));
      chk($sformatf("vec%0d_idle", i),  12'(s_idle),  12'(tv[i].idle));
    end

    // Burst ordering across sources
`ifdef SCHED_STRICT_PRIO_EN
    load(0, 8, 12'h010, 12'h101);
    load(3, 8, 12'hC30, 12'h101);
    for (int j = 0; j < 8; j++) exp_order.push_back(0);
    for (int j = 0; j < 8; j++) exp_order.push_back(3);
`else
    for (int s = 0; s < 4; s++) load(s, 6, 12'(s * 12'h400) + 12'h011, 12'h101);
    for (int s = 0; s < 4; s++) for (int j = 0; j < 4; j++) exp_order.push_back(s);
    for (int s = 0; s < 4; s++) for (int j = 0; j < 2; j++) exp_order.push_back(s);
`endif
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'h0, s_pop, s_push, s_dout, s_grant, s_idle);
      for (int i = 0; i < 4; i++) if (s_pop[i]) order.push_back(i);
    end
    chk("order_len", 12'(order.size()), 12'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < order.size(); i++)
      chk($sformatf("order%0d", i), 12'(order[i]), 12'(exp_order[i]));

    // Randomized traffic, back-pressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] af;
      if ($urandom_range(0, 3) == 0) begin
        int s;
        s = $urandom_range(0, 3);
        if (q[s].size() < 8) q[s].push_back(12'($urandom_range(0, 4095)));
      end
      af = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(($urandom_range(0, 199) == 0), af, s_pop, s_push, s_dout, s_grant, s_idle);
    end

    begin
      int guard;
      guard = 0;
      while (!(m_mode == M_IDLE && !m_pv && q[0].size() == 0 && q[1].size() == 0 &&
               q[2].size() == 0 && q[3].size() == 0) && guard < 200) begin
        step(1'b0, 4'h0, s_pop, s_push, s_dout, s_grant, s_idle);
        guard++;
      end
      chk("drain_done", 12'(guard < 200), 12'd1);
      chk("final_idle", 12'(bus.idle), 12'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
